// File: rtl/pipe_flow_pkg.sv
// Shared types for the pipeline flow controller and its output buffer.
package pipe_flow_pkg;

    localparam int BUF_DEPTH = 2;

    typedef logic [1:0] buf_count_t;
    typedef logic       buf_ptr_t;

    // Two-entry buffer: pointer advance is a simple toggle (1 wraps to 0).
    function automatic buf_ptr_t ptr_next(input buf_ptr_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/pipe_flow_ctrl_skid_buf2.sv
// Two-entry output FIFO that catches the pipeline tail so the upstream
// stall decision only ever looks at registered occupancy.
module skid_buf2
    import pipe_flow_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output buf_count_t       o_count,
    output logic [WIDTH-1:0] o_head_data
);

    logic [WIDTH-1:0] r_mem [BUF_DEPTH];
    buf_ptr_t         r_wr_ptr;
    buf_ptr_t         r_rd_ptr;
    buf_count_t       r_count;

    // Storage, pointers and occupancy; push and pop in one cycle keep count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count     = r_count;
    assign o_head_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Valid/ready controller for shared-enable delay chains. Tracks which
// pipeline slots carry data and drains the chain tail into a two-entry
// buffer; the chain enable depends on registered state only.
module pipe_flow_ctrl
    import pipe_flow_pkg::*;
#(
    parameter int CYCLES = 3,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             pipe_en,
    input  logic [WIDTH-1:0] pipe_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    logic [CYCLES:1]  r_vld;
    buf_count_t       w_count;
    logic             w_pipe_en;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;

    // Stall only when the tail holds a word and the buffer cannot take it
    // without relying on this cycle's pop (costs one bubble, no comb path).
    assign w_pipe_en = !r_vld[CYCLES] || (w_count < buf_count_t'(BUF_DEPTH));
    assign w_push    = w_pipe_en && r_vld[CYCLES];
    assign w_pop     = out_valid && out_ready;

    // Valid shadow of the data slots; shifts exactly when the chains do.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else if (w_pipe_en) begin
            r_vld[1] <= in_valid;
            for (int i = 2; i <= CYCLES; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    skid_buf2 #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (pipe_q),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head_data (w_head)
    );

    assign pipe_en   = w_pipe_en;
    assign in_ready  = w_pipe_en;
    assign out_valid = (w_count != '0);
    assign out_data  = w_head;
    assign busy      = (|r_vld) || (w_count != '0);

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Bench: two controllers (CYCLES=3 and CYCLES=1) share one stimulus stream,
// each wrapped around its own behavioural delay chain, each with its own
// scoreboard of accepted-but-not-delivered words.
module tb_pipe_flow_ctrl;

    localparam int W  = 8;
    localparam int NI = 2;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic [W-1:0] in_data;

    logic [NI-1:0]        in_ready;
    logic [NI-1:0]        pipe_en;
    logic [NI-1:0]        out_valid;
    logic [NI-1:0]        busy;
    logic [NI-1:0][W-1:0] pipe_q;
    logic [NI-1:0][W-1:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int CY = (g == 0) ? 3 : 1;

        logic [W-1:0] stg [CY];
        logic [W-1:0] exp_q [$];

        // External datapath: a plain enable-driven delay chain.
        always @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < CY; i++) stg[i] <= '0;
            end else if (pipe_en[g]) begin
                stg[0] <= in_data;
                for (int i = 1; i < CY; i++) stg[i] <= stg[i-1];
            end
        end
        assign pipe_q[g] = stg[CY-1];

        pipe_flow_ctrl #(
            .CYCLES (CY),
            .WIDTH  (W)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .pipe_en   (pipe_en[g]),
            .pipe_q    (pipe_q[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );

        // Scoreboard monitor: words in flight = accepted minus delivered.
        always @(negedge clk) begin
            int outst;
            if (rst) begin
                exp_q.delete();
            end else begin
                outst = exp_q.size();
                chk($sformatf("busy_i%0d", g), busy[g], (outst != 0));
                chk($sformatf("in_ready_eq_pe_i%0d", g), in_ready[g], pipe_en[g]);
                if (outst < 2) chk($sformatf("pe_low_occ_i%0d", g), pipe_en[g], 1);
                if (outst == CY + 2) chk($sformatf("pe_full_i%0d", g), pipe_en[g], 0);
                if (out_valid[g] && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL pop_empty_i%0d: got word %0h expected none", g, out_data[g]);
                    end else begin
                        chk($sformatf("data_i%0d", g), out_data[g], exp_q.pop_front());
                    end
                end
                if (in_valid && in_ready[g]) exp_q.push_back(in_data);
            end
        end
    end

    // One cycle of stimulus; pipe_en must not react to the new inputs.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, output logic acc0);
        logic [NI-1:0] pe_s;
        pe_s      = pipe_en;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        chk("pe_comb", pipe_en, pe_s);
        acc0 = v && in_ready[0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic a;
        int   k;
        int   nacc;
        logic [W-1:0] nd;
        logic [3:0] exp_ov;
        logic [3:0] exp_bz;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk("rst_out_valid", out_valid[i], 0);
            chk("rst_out_data",  out_data[i],  0);
            chk("rst_busy",      busy[i],      0);
            chk("rst_in_ready",  in_ready[i],  1);
            chk("rst_pipe_en",   pipe_en[i],   1);
        end

        // Continuous streaming: latency and gap-free throughput.
        nd = 8'd1;
        cyc(1'b1, nd, 1'b1, a);
        chk("first_accept", a, 1);
        if (a) nd++;
        k = 1;
        while (!out_valid[0] && k < 20) begin
            cyc(1'b1, nd, 1'b1, a);
            if (a) nd++;
            k++;
        end
        chk("latency_edges", k, 4);
        chk("first_data", out_data[0], 1);
        repeat (10) begin
            cyc(1'b1, nd, 1'b1, a);
            if (a) nd++;
            chk("no_gap", out_valid[0], 1);
        end

        // Downstream stall for 10 cycles, then resume.
        nacc = 0;
        repeat (10) begin
            cyc(1'b1, nd, 1'b0, a);
            if (a) begin nd++; nacc++; end
        end
        chk("stall_accepts", nacc, 1);
        chk("stall_pe", pipe_en[0], 0);
        chk("stall_ov", out_valid[0], 1);
        cyc(1'b1, nd, 1'b1, a);
        chk("resume_no_accept", a, 0);
        chk("resume_pe", pipe_en[0], 1);
        chk("resume_ov", out_valid[0], 1);
        repeat (6) begin
            cyc(1'b1, nd, 1'b1, a);
            if (a) nd++;
            chk("resume_stream", out_valid[0], 1);
        end

        // Drain, then alternating valid: A, bubble, B, bubble.
        repeat (10) cyc(1'b0, 8'h00, 1'b1, a);
        chk("drained_busy", busy[0], 0);
        cyc(1'b1, 8'hA5, 1'b1, a);
        chk("alt_accept_a", a, 1);
        cyc(1'b0, 8'h00, 1'b1, a);
        cyc(1'b1, 8'h5A, 1'b1, a);
        chk("alt_accept_b", a, 1);
        exp_ov = 4'b0101;
        exp_bz = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1, a);
            chk("alt_ov", out_valid[0], exp_ov[i]);
            chk("alt_busy", busy[0], exp_bz[i]);
            if (i == 0) chk("alt_data_a", out_data[0], 8'hA5);
            if (i == 2) chk("alt_data_b", out_data[0], 8'h5A);
        end

        // Fill pipeline and buffer, then reset mid-flight.
        repeat (6) begin
            cyc(1'b1, nd, 1'b1, a);
            if (a) nd++;
        end
        repeat (10) begin
            cyc(1'b1, nd, 1'b0, a);
            if (a) nd++;
        end
        chk("full_busy", busy[0], 1);
        chk("full_pe", pipe_en[0], 0);
        rst = 1'b1;
        cyc(1'b1, nd, 1'b0, a);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk("mid_rst_ov",  out_valid[i], 0);
            chk("mid_rst_busy", busy[i],     0);
            chk("mid_rst_ir",  in_ready[i],  1);
        end
        cyc(1'b1, 8'hC3, 1'b1, a);
        chk("x_accept", a, 1);
        cyc(1'b0, 8'h00, 1'b1, a);
        cyc(1'b0, 8'h00, 1'b1, a);
        chk("x_not_yet", out_valid[0], 0);
        cyc(1'b0, 8'h00, 1'b1, a);
        chk("x_ov", out_valid[0], 1);
        chk("x_data", out_data[0], 8'hC3);

        // Random traffic against both depths.
        repeat (800) begin
            cyc(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) != 0), a);
        end
        repeat (12) cyc(1'b0, 8'h00, 1'b1, a);
        for (int i = 0; i < NI; i++) chk("final_busy", busy[i], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_flow_ctrl.md
# pipe_flow_ctrl

Valid/ready flow controller for the enable-driven `delay` pipelines. It drives the shared `en` of one or more `CYCLES`-deep `delay` chains that carry the datapath. It tracks which pipeline slots hold valid data. It captures the chain tail into a 2-entry output buffer, so upstream stall decisions never depend combinationally on `out_ready`. It sits between an upstream valid/ready source and a downstream valid/ready sink, wrapped around the `delay` instances.

## Interface
Parameters:
- `CYCLES`, default 3: depth of the controlled `delay` chains; legal range ≥ 1.
- `WIDTH`, default 8: width of the datapath returned from the chain tails.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset; the same signal also resets the controlled `delay` chains.
- `in_valid`  in  1  upstream word valid; its data is driven straight onto the chains' `d`.
- `in_ready`  out  1  upstream handshake; equals `pipe_en`.
- `pipe_en`  out  1  enable to every controlled `delay` instance.
- `pipe_q`  in  WIDTH  concatenated `q` of the chains, i.e. slot `CYCLES`.
- `out_valid`  out  1  output buffer non-empty.
- `out_ready`  in  1  downstream accepts the head word.
- `out_data`  out  WIDTH  head of the output buffer.
- `busy`  out  1  any valid slot in the pipeline or any buffer entry.

## Operation
- Valid shadow register `vld[1..CYCLES]` mirrors the data slots.
  - When `pipe_en`=1: `vld[1]` ← `in_valid` and `vld[i]` ← `vld[i-1]`.
  - When `pipe_en`=0: `vld` holds.
- `pipe_en` = !`vld[CYCLES]` || (`count` < 2). It is a function of registered state only; there is no path from `in_valid` or `out_ready`.
- Push: `pipe_en` && `vld[CYCLES]` writes `pipe_q` into the buffer at `wr_ptr`.
- Pop: `out_valid` && `out_ready` advances `rd_ptr`.
- Output buffer: 2 entries, 1-bit pointers that wrap 1→0, `count` in 0..2.
  - Simultaneous push and pop: `count` is unchanged and both pointers advance.
  - With `count`=2, a pop in the same cycle does not enable a push. This costs one bubble by design.
  - Push while full cannot occur, because `pipe_en`=0 whenever `count`=2 and `vld[CYCLES]`=1.
  - Pop while empty cannot occur, because `out_valid`=0.
- The whole pipeline advances as a unit, because all stages share one `en`. Bubbles are not collapsed while stalled.
- `out_valid` = (`count` != 0). `out_data` = `mem[rd_ptr]`.
- `busy` = |`vld` || (`count` != 0).

## Timing
- Reset values:
  - `vld`=0, `count`=0, pointers=0, `mem`=0.
  - Outputs: `out_valid`=0, `out_data`=0, `busy`=0, `pipe_en`=`in_ready`=1.
- Latency: a word accepted at edge T, with no stall, is pushed at edge T+CYCLES. `out_valid` is 1 in the cycle after that edge: CYCLES+1 edges in total.
- Throughput is one word per cycle while `out_ready`=1, with steady-state `count`=1.
- Stall: after `out_ready` drops, at most 2 further words land in the buffer. `pipe_en` then falls in the same cycle `count` reaches 2 with `vld[CYCLES]`=1.
- Resume: `out_ready`=1 pops at once. `pipe_en` re-asserts one cycle later, when `count`=1.
- Reset asserted mid-operation: all in-flight and buffered words are discarded. The state listed above is restored on the next edge, and the `delay` chains clear on the same edge.
- `in_valid`=0 while `in_ready`=1 inserts a bubble that propagates normally.

## Structure
- Package `pipe_flow_pkg`:
  - `localparam int BUF_DEPTH = 2`.
  - `typedef logic [1:0] buf_count_t`.
  - `typedef logic buf_ptr_t`.
- Sub-module `skid_buf2`, parameterised on `WIDTH`:
  - Ports: `clk`, `rst`, push, push data, pop, `count`, head data.
  - Instantiated once.
- The valid shadow shift register lives in the top module, beside the `pipe_en` logic.
- The datapath `delay` instances stay outside this block.

## Test plan
- Reset, then `CYCLES`=3 with continuous `in_valid` carrying data 1,2,3… and `out_ready`=1:
  - first `out_valid` occurs 4 edges after the first accept, with `out_data`=1;
  - then one word per cycle, in order, with no gaps.
- Streaming, then `out_ready`=0 for 10 cycles:
  - `count` saturates at 2 and `pipe_en` drops;
  - no word is lost or duplicated, and after `out_ready`=1 the sequence continues in order.
- `count`=2 with `out_ready`=1 and `vld[CYCLES]`=1:
  - pop occurs, push does not; the next cycle pushes.
  - One bubble is inserted and order is preserved.
- Alternating `in_valid` 1/0 with data A,–,B,–:
  - output is A, B with one-cycle gaps;
  - `busy` falls to 0 exactly one cycle after the B pop.
- `rst` asserted while 3 words are in flight and 2 are buffered:
  - next cycle `out_valid`=0, `busy`=0, `in_ready`=1;
  - a new word X then emerges as the first output after CYCLES+1 edges.
- `CYCLES`=1 with random `in_valid` and `out_ready`: a scoreboard shows in-order, lossless transfer, and `pipe_en` never changes combinationally with `out_ready`.
